// File: rtl/pattern_pkg.sv
// Framing constants and state encoding shared by the pattern transmitter
// and the receive-side 1010/1001 detectors.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOM  = 2'd3
    } tx_state_e;

    localparam int              MARK_W    = 4;
    localparam logic [MARK_W-1:0] SYNC_MARK = 4'b1010;
    localparam logic [MARK_W-1:0] EOM_MARK  = 4'b1001;

    // Marker bits go out MSB-first, so position 0 is the leftmost bit.
    function automatic logic mark_bit(input logic [MARK_W-1:0] mark, input logic [1:0] idx);
        return mark[2'd3 - idx];
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register: loads a word, shifts left on demand,
// and presents the current MSB.
module piso_shift
    import pattern_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = data_q << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/framed_pattern_tx.sv
// Serial frame transmitter: sync marker 1010, payload MSB-first, end marker 1001,
// one bit per clock, with back-to-back frames accepted on the last end-marker bit.
module framed_pattern_tx
    import pattern_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt
);

    localparam int CNT_SPAN = (DATA_W > MARK_W) ? DATA_W : MARK_W;
    localparam int BIDX_W   = $clog2(CNT_SPAN);
    localparam logic [BIDX_W-1:0] LAST_MARK = BIDX_W'(MARK_W - 1);
    localparam logic [BIDX_W-1:0] LAST_DATA = BIDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [BIDX_W-1:0] bit_idx_q, bit_idx_d;
    logic              sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic accept;
    logic load;
    logic shift;
    logic shift_msb;

    piso_shift #(
        .WIDTH (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (din),
        .msb   (shift_msb)
    );

    assign din_ready = (state_q == IDLE) || ((state_q == EOM) && (bit_idx_q == LAST_MARK));
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SYNC;
                    bit_idx_d = '0;
                    load      = 1'b1;
                end
            end
            SYNC: begin
                if (bit_idx_q == LAST_MARK) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_idx_q == LAST_DATA) begin
                    state_d   = EOM;
                    bit_idx_d = '0;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            EOM: begin
                if (bit_idx_q == LAST_MARK) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    bit_idx_d   = '0;
                    if (accept) begin
                        state_d = SYNC;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase

        // Outputs are registered from the next state, so the shifter steps on the
        // same edge that latches its MSB into sout.
        shift        = (state_d == DATA);
        sout_valid_d = (state_d != IDLE);
        frame_done_d = (state_d == EOM) && (bit_idx_d == LAST_MARK);

        case (state_d)
            SYNC:    sout_d = mark_bit(SYNC_MARK, bit_idx_d[1:0]);
            DATA:    sout_d = shift_msb;
            EOM:     sout_d = mark_bit(EOM_MARK, bit_idx_d[1:0]);
            default: sout_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
